// File: rtl/cluster_pkg.sv
// -----------------------------------------------------------------------------
// cluster_pkg
// Shared constants and types for the cluster count monitor slice.
//   CNT_W        : default width of the per-BX cluster count
//   MAX_CLUSTERS : default overflow threshold (counts strictly above it flag)
//   BX_PHASES    : fabric clock cycles per bunch crossing
//   state_t      : monitor FSM state (IDLE, ACCUM)
// -----------------------------------------------------------------------------
package cluster_pkg;

    localparam int CNT_W        = 8;
    localparam int MAX_CLUSTERS = 8;
    localparam int BX_PHASES    = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

endpackage : cluster_pkg

// File: rtl/ccm_snapshot.sv
// -----------------------------------------------------------------------------
// ccm_snapshot
// Holds the per-window statistics snapshot handed to slow control and runs
// the valid/ack handshake plus the sticky lost-snapshot indication.
// Ports:
//   clock4x, reset_n   : fabric clock, asynchronous active-low reset
//   clear              : synchronous restart, drops valid and lost
//   close              : window closes this cycle, *_in carry final values
//   ovf_in/peak_in/sum_in : window statistics including the closing sample
//   snap_ack           : consumer has taken the snapshot
//   snap_valid         : snapshot registers hold unread data
//   snap_ovf/peak/sum  : snapshot contents
//   snap_lost          : sticky, a window closed over an unread snapshot
// -----------------------------------------------------------------------------
module ccm_snapshot #(
    parameter int CNT_W     = 8,
    parameter int SUM_W     = 20,
    parameter int OVF_CNT_W = 16
) (
    input  logic                 clock4x,
    input  logic                 reset_n,
    input  logic                 clear,
    input  logic                 close,
    input  logic [OVF_CNT_W-1:0] ovf_in,
    input  logic [CNT_W-1:0]     peak_in,
    input  logic [SUM_W-1:0]     sum_in,
    input  logic                 snap_ack,
    output logic                 snap_valid,
    output logic [OVF_CNT_W-1:0] snap_ovf,
    output logic [CNT_W-1:0]     snap_peak,
    output logic [SUM_W-1:0]     snap_sum,
    output logic                 snap_lost
);

    // NOTE: sequential state is written with non-blocking assignments only, so
    // every register samples pre-edge values regardless of statement order.
    always_ff @(posedge clock4x or negedge reset_n) begin
        if (!reset_n) begin
            snap_valid <= 1'b0;
            snap_lost  <= 1'b0;
            snap_ovf   <= '0;
            snap_peak  <= '0;
            snap_sum   <= '0;
        end else if (clear) begin
            snap_valid <= 1'b0;
            snap_lost  <= 1'b0;
        end else if (close) begin
            // An ack arriving together with the close frees the slot in time
            // for the new window, so nothing is lost.
            if (!snap_valid || snap_ack) begin
                snap_valid <= 1'b1;
                snap_ovf   <= ovf_in;
                snap_peak  <= peak_in;
                snap_sum   <= sum_in;
            end else begin
                snap_lost  <= 1'b1;
            end
        end else if (snap_ack && snap_valid) begin
            snap_valid <= 1'b0;
        end
    end

endmodule : ccm_snapshot

// File: rtl/cluster_count_monitor.sv
// -----------------------------------------------------------------------------
// cluster_count_monitor
// Samples the per-BX cluster count once per bunch crossing, flags overflow
// BXs and accumulates per-window overflow count, peak and sum. At each window
// close a snapshot is published through ccm_snapshot.
// Ports:
//   clock4x, reset_n : fabric clock (4 cycles per BX), async active-low reset
//   bx0              : pulse marking phase 0 of a BX
//   cnt_in           : cluster count from the counter stage
//   enable           : accumulation enable (low discards the partial window)
//   clear            : synchronous restart of window and statistics
//   snap_ack         : slow control has taken the snapshot
//   ovf_flag         : overflow indication for the last sampled BX
//   window_done      : one-cycle pulse after the closing strobe
//   snap_*           : snapshot handshake and contents
// Build option:
//   CLUSTER_COUNT_MONITOR_OVF_STRETCH_EN : hold ovf_flag for STRETCH_BX
//   further strobes after the last overflow BX.
// -----------------------------------------------------------------------------
module cluster_count_monitor #(
    parameter int CNT_W        = cluster_pkg::CNT_W,
    parameter int MAX_CLUSTERS = cluster_pkg::MAX_CLUSTERS,
    parameter int SAMPLE_PHASE = 3,
    parameter int WINDOW_LOG2  = 12,
    parameter int OVF_CNT_W    = 16,
    parameter int STRETCH_BX   = 4
) (
    input  logic                         clock4x,
    input  logic                         reset_n,
    input  logic                         bx0,
    input  logic [CNT_W-1:0]             cnt_in,
    input  logic                         enable,
    input  logic                         clear,
    input  logic                         snap_ack,
    output logic                         ovf_flag,
    output logic                         window_done,
    output logic                         snap_valid,
    output logic [OVF_CNT_W-1:0]         snap_ovf,
    output logic [CNT_W-1:0]             snap_peak,
    output logic [CNT_W+WINDOW_LOG2-1:0] snap_sum,
    output logic                         snap_lost
);

    import cluster_pkg::*;

    localparam int SUM_W = CNT_W + WINDOW_LOG2;
    localparam int PH_W  = $clog2(BX_PHASES);

    // Phase tracking: bx0 defines the current cycle as phase 0, the register
    // carries the phase expected for the following cycle.
    logic [PH_W-1:0] phase;
    logic [PH_W-1:0] cur_phase;
    logic            strobe;

    assign cur_phase = bx0 ? '0 : phase;
    assign strobe    = (cur_phase == PH_W'(SAMPLE_PHASE));

    always_ff @(posedge clock4x or negedge reset_n) begin
        if (!reset_n) phase <= '0;
        else          phase <= cur_phase + 1'b1;
    end

    // Window accumulators
    state_t                 state;
    logic [WINDOW_LOG2-1:0] bx_idx;
    logic [SUM_W-1:0]       acc_sum;
    logic [CNT_W-1:0]       acc_peak;
    logic [OVF_CNT_W-1:0]   acc_ovf;

    logic                   is_ovf;
    logic                   accum_go;
    logic                   win_close;
    logic [WINDOW_LOG2-1:0] base_idx;
    logic [SUM_W-1:0]       next_sum;
    logic [CNT_W-1:0]       next_peak;
    logic [OVF_CNT_W-1:0]   next_ovf;

    assign is_ovf = (cnt_in > CNT_W'(MAX_CLUSTERS));

    // NOTE: every always_comb output gets a default first so no path leaves a
    // value unassigned and no latch is inferred.
    always_comb begin
        base_idx  = '0;
        next_sum  = SUM_W'(cnt_in);
        next_peak = cnt_in;
        next_ovf  = is_ovf ? OVF_CNT_W'(1) : '0;
        // IDLE holds the accumulators at zero, so the first strobe simply
        // loads the sample; ACCUM folds the sample into the running totals.
        if (state == ACCUM) begin
            base_idx  = bx_idx;
            next_sum  = acc_sum + SUM_W'(cnt_in);
            next_peak = (cnt_in > acc_peak) ? cnt_in : acc_peak;
            next_ovf  = (is_ovf && (acc_ovf != '1)) ? acc_ovf + 1'b1 : acc_ovf;
        end
    end

    assign accum_go  = strobe && enable && !clear;
    assign win_close = accum_go && (base_idx == '1);

    always_ff @(posedge clock4x or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            bx_idx      <= '0;
            acc_sum     <= '0;
            acc_peak    <= '0;
            acc_ovf     <= '0;
            window_done <= 1'b0;
        end else begin
            window_done <= 1'b0;
            if (clear || !enable) begin
                state    <= IDLE;
                bx_idx   <= '0;
                acc_sum  <= '0;
                acc_peak <= '0;
                acc_ovf  <= '0;
            end else if (strobe) begin
                state <= ACCUM;
                if (win_close) begin
                    // Closing sample goes to the snapshot, totals restart.
                    window_done <= 1'b1;
                    bx_idx      <= '0;
                    acc_sum     <= '0;
                    acc_peak    <= '0;
                    acc_ovf     <= '0;
                end else begin
                    bx_idx   <= base_idx + 1'b1;
                    acc_sum  <= next_sum;
                    acc_peak <= next_peak;
                    acc_ovf  <= next_ovf;
                end
            end
        end
    end

    // Overflow flag, updated on every strobe independent of the FSM
`ifdef CLUSTER_COUNT_MONITOR_OVF_STRETCH_EN
    localparam int STR_W = $clog2(STRETCH_BX + 1);
    logic [STR_W-1:0] stretch_cnt;

    always_ff @(posedge clock4x or negedge reset_n) begin
        if (!reset_n) begin
            ovf_flag    <= 1'b0;
            stretch_cnt <= '0;
        end else if (strobe) begin
            if (is_ovf) begin
                ovf_flag    <= 1'b1;
                stretch_cnt <= STR_W'(STRETCH_BX);
            end else if (stretch_cnt != '0) begin
                ovf_flag    <= 1'b1;
                stretch_cnt <= stretch_cnt - 1'b1;
            end else begin
                ovf_flag    <= 1'b0;
            end
        end
    end
`else
    always_ff @(posedge clock4x or negedge reset_n) begin
        if (!reset_n)    ovf_flag <= 1'b0;
        else if (strobe) ovf_flag <= is_ovf;
    end
`endif

    ccm_snapshot #(
        .CNT_W     (CNT_W),
        .SUM_W     (SUM_W),
        .OVF_CNT_W (OVF_CNT_W)
    ) u_snapshot (
        .clock4x    (clock4x),
        .reset_n    (reset_n),
        .clear      (clear),
        .close      (win_close),
        .ovf_in     (next_ovf),
        .peak_in    (next_peak),
        .sum_in     (next_sum),
        .snap_ack   (snap_ack),
        .snap_valid (snap_valid),
        .snap_ovf   (snap_ovf),
        .snap_peak  (snap_peak),
        .snap_sum   (snap_sum),
        .snap_lost  (snap_lost)
    );

endmodule : cluster_count_monitor
